// File: rtl/mp_pkg.sv
// Shared opcode encodings and decode helpers for the mp pipeline tile.
package mp_pkg;

  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OPC_MIN = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_ADD = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_XOR = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_MAX = OPC_W'(7);
  localparam logic [OPC_W-1:0] OPC_AVG = OPC_W'(9);
  localparam logic [OPC_W-1:0] OPC_NOT = OPC_W'(10);
  localparam logic [OPC_W-1:0] OPC_AND = OPC_W'(11);
  localparam logic [OPC_W-1:0] OPC_NEG = OPC_W'(12);
  localparam logic [OPC_W-1:0] OPC_ABS = OPC_W'(13);
  localparam logic [OPC_W-1:0] OPC_OR  = OPC_W'(14);
  localparam logic [OPC_W-1:0] OPC_SUB = OPC_W'(15);

  // True for the eleven implemented opcodes; everything else retires as an error.
  function automatic logic opc_valid(input logic [OPC_W-1:0] opc);
    logic ok;
    case (opc)
      OPC_MIN, OPC_ADD, OPC_XOR, OPC_MAX, OPC_AVG, OPC_NOT,
      OPC_AND, OPC_NEG, OPC_ABS, OPC_OR, OPC_SUB: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mp_alu.sv
// Combinational 11-op ALU; unknown opcodes flag err and return zero.
module mp_alu
  import mp_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [OPC_W-1:0]  opc,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic [DATA_W:0] avg_sum;
  logic            a_lt_b;

  // Sign-extended sum so the average never loses the carry.
  assign avg_sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign a_lt_b  = $signed(a) < $signed(b);

  // Opcode decode and result select.
  always_comb begin
    result = '0;
    err    = !opc_valid(opc);
    case (opc)
      OPC_ADD: result = a + b;
      OPC_SUB: result = a - b;
      OPC_ABS: result = a[DATA_W-1] ? (~a + DATA_W'(1)) : a;
      OPC_NEG: result = DATA_W'(0) - a;
      OPC_MAX: result = a_lt_b ? b : a;
      OPC_MIN: result = a_lt_b ? a : b;
      OPC_AVG: result = DATA_W'(avg_sum >> 1);
      OPC_NOT: result = ~a;
      OPC_OR:  result = a | b;
      OPC_AND: result = a & b;
      OPC_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mp_pipe_top.sv
// Two-stage pipelined core: operand fetch with bypass, ALU stage, result/writeback stage.
module mp_pipe_top
  import mp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [OPC_W+3*ADDR_W-1:0]    instr,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  output logic [DATA_W-1:0]            res_data,
  output logic                         res_err,
  output logic                         res_valid,
  input  logic                         res_ready,
  input  logic                         ld_en,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [DATA_W-1:0]            ld_data,
  output logic [CNT_W-1:0]             retire_cnt
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  logic [OPC_W-1:0]  dec_opc;
  logic [ADDR_W-1:0] dec_src1;
  logic [ADDR_W-1:0] dec_src2;
  logic [ADDR_W-1:0] dec_dst;

  logic              s1_valid;
  logic [OPC_W-1:0]  s1_opc;
  logic [ADDR_W-1:0] s1_dst;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [ADDR_W-1:0] s2_dst;

  logic [DATA_W-1:0] alu_res;
  logic              alu_err;

  logic              stall_c;
  logic              accept_c;
  logic              retire_c;
  logic              wb_c;
  logic [DATA_W-1:0] op_a_c;
  logic [DATA_W-1:0] op_b_c;

  assign dec_opc  = instr[OPC_W-1:0];
  assign dec_src1 = instr[OPC_W +: ADDR_W];
  assign dec_src2 = instr[OPC_W+ADDR_W +: ADDR_W];
  assign dec_dst  = instr[OPC_W+2*ADDR_W +: ADDR_W];

  // A held result freezes the whole pipe; preload and reset also block issue.
  assign stall_c     = res_valid && !res_ready;
  assign instr_ready = !stall_c && !ld_en && !rst;
  assign accept_c    = instr_valid && instr_ready;
  assign retire_c    = res_valid && res_ready;
  assign wb_c        = retire_c && !res_err;

  mp_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opc    (s1_opc),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_res),
    .err    (alu_err)
  );

  // Operand select: youngest in-flight producer wins, error results are never forwarded.
  always_comb begin
    op_a_c = regs[dec_src1];
    op_b_c = regs[dec_src2];
    if (res_valid && !res_err && (s2_dst == dec_src1)) op_a_c = res_data;
    if (res_valid && !res_err && (s2_dst == dec_src2)) op_b_c = res_data;
    if (s1_valid && !alu_err && (s1_dst == dec_src1))  op_a_c = alu_res;
    if (s1_valid && !alu_err && (s1_dst == dec_src2))  op_b_c = alu_res;
  end

  // Pipeline stages: S1 holds decoded operands, S2 is the visible result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_opc    <= '0;
      s1_dst    <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      s2_dst    <= '0;
    end else if (!stall_c) begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_opc <= dec_opc;
        s1_dst <= dec_dst;
        s1_a   <= op_a_c;
        s1_b   <= op_b_c;
      end
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_data <= alu_res;
        res_err  <= alu_err;
        s2_dst   <= s1_dst;
      end
    end
  end

  // Register file: writeback takes precedence over a same-address host preload.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (rst) begin
        regs[i] <= '0;
      end else if (wb_c && (s2_dst == ADDR_W'(i))) begin
        regs[i] <= res_data;
      end else if (ld_en && (ld_addr == ADDR_W'(i))) begin
        regs[i] <= ld_data;
      end
    end
  end

  // Retire counter advances on every result handshake, errors included.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire_c) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mp_pipe_top.sv
// Directed plus randomized bench for mp_pipe_top against a sequential ISA model.
module tb_mp_pipe_top;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IW     = 6 + 3*ADDR_W;

  localparam logic [5:0] T_ADD = 6'd3,  T_SUB = 6'd15, T_ABS = 6'd13, T_NEG = 6'd12;
  localparam logic [5:0] T_MAX = 6'd7,  T_MIN = 6'd1,  T_AVG = 6'd9,  T_NOT = 6'd10;
  localparam logic [5:0] T_OR  = 6'd14, T_AND = 6'd11, T_XOR = 6'd5;

  logic              clk = 1'b0;
  logic              rst;
  logic [IW-1:0]     instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic              res_valid;
  logic              res_ready;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [CNT_W-1:0]  retire_cnt;

  typedef struct packed {
    logic [4:0]  dst;
    logic        e;
    logic [31:0] d;
  } exp_t;

  logic [31:0] mregs [32];
  exp_t        expq [$];
  int unsigned mcnt;
  int unsigned idle;
  logic [31:0] last_d;
  logic        last_e;
  int          n_checks;
  int          n_pass;
  logic [5:0]  ops [11];

  mp_pipe_top #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .res_data    (res_data),
    .res_err     (res_err),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Architectural meaning of each opcode; returns {err, data}.
  function automatic logic [32:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sa;
    int          sb;
    longint      s;
    logic [31:0] r;
    logic        e;
    sa = $signed(a);
    sb = $signed(b);
    e  = 1'b0;
    r  = 32'h0;
    case (op)
      T_ADD: r = a + b;
      T_SUB: r = a - b;
      T_ABS: r = (sa < 0) ? 32'(-sa) : a;
      T_NEG: r = 32'(-sa);
      T_MAX: r = (sa > sb) ? a : b;
      T_MIN: r = (sa < sb) ? a : b;
      T_AVG: begin s = longint'(sa) + longint'(sb); r = 32'(s >>> 1); end
      T_NOT: r = ~a;
      T_OR:  r = a | b;
      T_AND: r = a & b;
      T_XOR: r = a ^ b;
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  function automatic logic [IW-1:0] mk(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [4:0] d);
    return {d, s2, s1, op};
  endfunction

  // One clock: predict what the edge does from pre-edge values, then check after it.
  task automatic cycle();
    logic        acc;
    logic        ret;
    logic        blocked;
    exp_t        e;
    logic [32:0] r;
    @(negedge clk);
    acc = instr_valid && instr_ready;
    ret = res_valid && res_ready;
    if (rst) begin
      foreach (mregs[i]) mregs[i] = 32'h0;
      expq.delete();
      mcnt = 0;
      idle = 0;
    end else begin
      if (ld_en) begin
        blocked = 1'b0;
        foreach (expq[i]) if (!expq[i].e && expq[i].dst == ld_addr) blocked = 1'b1;
        if (!blocked) mregs[ld_addr] = ld_data;
      end
      if (ret) begin
        if (expq.size() == 0) begin
          check("unexpected_retire", 64'(res_valid), 64'(0));
        end else begin
          e = expq.pop_front();
          check("res_data", 64'(res_data), 64'(e.d));
          check("res_err", 64'(res_err), 64'(e.e));
        end
        last_d = res_data;
        last_e = res_err;
        mcnt++;
        idle = 0;
      end else if (expq.size() != 0) begin
        idle++;
        if (idle > 64) begin
          check("result_timeout", 64'(idle), 64'(0));
          idle = 0;
        end
      end
      if (acc) begin
        r     = ref_alu(instr[5:0], mregs[instr[10:6]], mregs[instr[15:11]]);
        e.d   = r[31:0];
        e.e   = r[32];
        e.dst = instr[20:16];
        if (!e.e) mregs[e.dst] = e.d;
        expq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check("retire_cnt", 64'(retire_cnt), 64'(mcnt[15:0]));
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    instr       = mk(op, s1, s2, d);
    instr_valid = 1'b1;
    cycle();
    instr_valid = 1'b0;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    cycle();
    ld_en   = 1'b0;
  endtask

  task automatic drain();
    instr_valid = 1'b0;
    res_ready   = 1'b1;
    for (int i = 0; i < 8 && (expq.size() != 0 || res_valid); i++) cycle();
    check("drain_queue_empty", 64'(expq.size()), 64'(0));
    check("drain_res_valid", 64'(res_valid), 64'(0));
  endtask

  task automatic read_reg(input logic [4:0] a, input logic [31:0] exp, input string tag);
    issue(T_OR, a, a, a);
    drain();
    check(tag, 64'(last_d), 64'(exp));
  endtask

  task automatic alu_vec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
    preload(5'd6, a);
    preload(5'd7, b);
    issue(op, 5'd6, 5'd7, 5'd8);
    drain();
    check(tag, 64'(last_d), 64'(exp));
  endtask

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
    return ops[$urandom_range(0, 10)];
  endfunction

  initial begin
    logic [31:0] cnt0;
    int unsigned k;
    ops = '{T_ADD, T_SUB, T_ABS, T_NEG, T_MAX, T_MIN, T_AVG, T_NOT, T_OR, T_AND, T_XOR};
    foreach (mregs[i]) mregs[i] = 32'h0;
    mcnt = 0; idle = 0; n_checks = 0; n_pass = 0; last_d = 32'h0; last_e = 1'b0;
    rst = 1'b1; instr = '0; instr_valid = 1'b0; res_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr_ready", 64'(instr_ready), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_res_err", 64'(res_err), 64'(0));
    check("rst_retire_cnt", 64'(retire_cnt), 64'(0));
    rst = 1'b0;
    #1;
    check("idle_instr_ready", 64'(instr_ready), 64'(1));

    // Basic ADD with two-edge latency.
    preload(5'd1, 32'h1066);
    preload(5'd2, 32'h15dc);
    issue(T_ADD, 5'd1, 5'd2, 5'd3);
    check("lat_one_edge_valid", 64'(res_valid), 64'(0));
    cycle();
    check("lat_two_edge_valid", 64'(res_valid), 64'(1));
    check("lat_two_edge_data", 64'(res_data), 64'(32'h2642));
    drain();
    read_reg(5'd3, 32'h2642, "r3_after_add");

    // Back-to-back dependency through S1.
    preload(5'd3, 32'h0);
    issue(T_ADD, 5'd1, 5'd2, 5'd3);
    issue(T_SUB, 5'd3, 5'd1, 5'd4);
    drain();
    check("s1_bypass_sub", 64'(last_d), 64'(32'h15dc));

    // One-cycle gap dependency through S2.
    preload(5'd3, 32'h0);
    issue(T_ADD, 5'd1, 5'd2, 5'd3);
    cycle();
    issue(T_SUB, 5'd3, 5'd1, 5'd4);
    drain();
    check("s2_bypass_sub", 64'(last_d), 64'(32'h15dc));

    // Invalid opcode: error, zero data, no writeback, still counted.
    preload(5'd5, 32'h7);
    cnt0 = mcnt;
    issue(6'd0, 5'd1, 5'd2, 5'd5);
    drain();
    check("bad_op_err", 64'(last_e), 64'(1));
    check("bad_op_data", 64'(last_d), 64'(0));
    check("bad_op_retire", 64'(retire_cnt), 64'(16'(cnt0 + 1)));
    read_reg(5'd5, 32'h7, "r5_untouched");

    // ALU corner vectors.
    alu_vec(T_AVG, 32'hFFFF_FFFF, 32'h1, 32'h0, "avg_m1_p1");
    alu_vec(T_MAX, 32'hFFFF_FFF0, 32'h5, 32'h5, "max_signed");
    alu_vec(T_MIN, 32'hFFFF_FFF0, 32'h5, 32'hFFFF_FFF0, "min_signed");
    alu_vec(T_NEG, 32'h1066, 32'h0, 32'hFFFF_EF9A, "neg_1066");
    alu_vec(T_ABS, 32'h8000_0000, 32'h0, 32'h8000_0000, "abs_most_neg");
    alu_vec(T_ADD, 32'hFFFF_FFFF, 32'h2, 32'h1, "add_wrap");
    alu_vec(T_AVG, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "avg_no_overflow");

    // Writeback and preload to the same register on the same edge.
    preload(5'd3, 32'h0);
    issue(T_ADD, 5'd1, 5'd2, 5'd3);
    cycle();
    preload(5'd3, 32'hDEAD);
    read_reg(5'd3, 32'h2642, "wb_beats_preload");

    // Backpressure with two instructions in flight.
    cnt0 = mcnt;
    res_ready = 1'b0;
    issue(T_ADD, 5'd1, 5'd2, 5'd3);
    issue(T_SUB, 5'd3, 5'd1, 5'd4);
    check("stall_res_valid", 64'(res_valid), 64'(1));
    instr = mk(T_ADD, 5'd1, 5'd1, 5'd9);
    instr_valid = 1'b1;
    repeat (3) begin
      cycle();
      check("stall_instr_ready", 64'(instr_ready), 64'(0));
      check("stall_res_data", 64'(res_data), 64'(32'h2642));
    end
    drain();
    check("stall_retire_plus2", 64'(retire_cnt), 64'(16'(cnt0 + 2)));
    check("stall_last_data", 64'(last_d), 64'(32'h15dc));

    // Source equal to destination reads the old value.
    issue(T_ADD, 5'd1, 5'd1, 5'd1);
    drain();
    check("src_eq_dst", 64'(last_d), 64'(32'h20cc));

    // Reset with two instructions in flight.
    issue(T_ADD, 5'd1, 5'd2, 5'd10);
    issue(T_ADD, 5'd1, 5'd2, 5'd11);
    rst = 1'b1;
    cycle();
    check("rst_flight_res_valid", 64'(res_valid), 64'(0));
    check("rst_flight_retire_cnt", 64'(retire_cnt), 64'(0));
    rst = 1'b0;
    read_reg(5'd10, 32'h0, "rst_r10_zero");
    read_reg(5'd11, 32'h0, "rst_r11_zero");
    read_reg(5'd1, 32'h0, "rst_r1_zero");

    // Randomized traffic with backpressure, preloads and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      k           = $urandom_range(0, 199);
      rst         = (k == 0);
      ld_en       = (k >= 1 && k < 20);
      ld_addr     = 5'($urandom_range(0, 7));
      ld_data     = pick_data();
      res_ready   = ($urandom_range(0, 3) != 0);
      instr_valid = ($urandom_range(0, 9) < 7);
      instr       = mk(pick_op(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)));
      cycle();
    end
    rst = 1'b0;
    ld_en = 1'b0;
    drain();
    for (int a = 0; a < 8; a++) begin
      issue(T_OR, 5'(a), 5'(a), 5'(a));
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
